// File: rtl/mem_stage_sram.sv
// rtl/mem_stage_sram.sv - ARM pipeline memory stage: word LDR/STR over a 16-bit async SRAM, plus MEM/WB register
module mem_stage_sram #(
  parameter int WAIT_CYCLES = 5,
  parameter int ADDR_BASE   = 1024,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               WB_ENIn,
  input  logic               MEM_R_ENIn,
  input  logic               MEM_W_ENIn,
  input  logic [31:0]        ALU_ResIn,
  input  logic [31:0]        Val_RmIn,
  input  logic [3:0]         DestIn,
  output logic               freezeOut,
  output logic               WB_ENOut,
  output logic               MEM_R_ENOut,
  output logic [31:0]        ALU_ResOut,
  output logic [31:0]        MEM_ResOut,
  output logic [3:0]         DestOut,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_DQ_Out,
  input  logic [15:0]        SRAM_DQ_In,
  output logic               SRAM_DQ_OE,
  output logic               SRAM_WE_N
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [15:0]        rd_lo;
  logic [15:0]        rd_hi;
  logic               req;
  logic               last;
  logic               in_low;
  logic               in_high;
  logic               store_phase;
  logic [SRAM_AW-2:0] idx;

  assign req         = MEM_R_ENIn | MEM_W_ENIn;
  assign last        = (cnt == CNT_LAST);
  assign in_low      = (state == S_LOW);
  assign in_high     = (state == S_HIGH);
  assign store_phase = MEM_W_ENIn & (in_low | in_high);

  // Word index relative to the SRAM window; wraps modulo 2^32 and truncates silently.
  assign idx = (SRAM_AW-1)'((ALU_ResIn - 32'(ADDR_BASE)) >> 2);

  // Upstream stalls for the whole access except the final DONE cycle, which lets the result retire.
  assign freezeOut = rst & req & (state != S_DONE);

  assign SRAM_ADDR   = in_low  ? {idx, 1'b0} :
                       in_high ? {idx, 1'b1} : '0;
  assign SRAM_DQ_OE  = store_phase;
  // Write strobe releases on the last cycle of each half so data/address stay stable past the rising edge.
  assign SRAM_WE_N   = ~(store_phase & ~last);
  assign SRAM_DQ_Out = (MEM_W_ENIn & in_low)  ? Val_RmIn[15:0]  :
                       (MEM_W_ENIn & in_high) ? Val_RmIn[31:16] : 16'h0000;

  // Wait-state FSM: low half-word, high half-word, then one DONE cycle to release the freeze.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            state <= S_LOW;
            cnt   <= '0;
          end
        end
        S_LOW: begin
          if (last) begin
            state <= S_HIGH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (last) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Load data is sampled at the end of each half, once the SRAM has had the full wait time.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_lo <= 16'h0000;
      rd_hi <= 16'h0000;
    end else begin
      if (MEM_R_ENIn && in_low && last) begin
        rd_lo <= SRAM_DQ_In;
      end
      if (MEM_R_ENIn && in_high && last) begin
        rd_hi <= SRAM_DQ_In;
      end
    end
  end

  // MEM/WB register: captures when not frozen, otherwise inserts a bubble and holds the data fields.
  always_ff @(posedge clk) begin
    if (!rst) begin
      WB_ENOut    <= 1'b0;
      MEM_R_ENOut <= 1'b0;
      ALU_ResOut  <= 32'h0;
      MEM_ResOut  <= 32'h0;
      DestOut     <= 4'h0;
    end else if (freezeOut) begin
      WB_ENOut    <= 1'b0;
      MEM_R_ENOut <= 1'b0;
    end else begin
      WB_ENOut    <= WB_ENIn;
      MEM_R_ENOut <= MEM_R_ENIn;
      ALU_ResOut  <= ALU_ResIn;
      MEM_ResOut  <= {rd_hi, rd_lo};
      DestOut     <= DestIn;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// tb/tb_mem_stage_sram.sv - scoreboard bench for mem_stage_sram
module tb_mem_stage_sram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        WB_ENIn, MEM_R_ENIn, MEM_W_ENIn;
  logic [31:0] ALU_ResIn, Val_RmIn;
  logic [3:0]  DestIn;
  logic        freezeOut, WB_ENOut, MEM_R_ENOut;
  logic [31:0] ALU_ResOut, MEM_ResOut;
  logic [3:0]  DestOut;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_Out, SRAM_DQ_In;
  logic        SRAM_DQ_OE, SRAM_WE_N;

  logic        d2_wb, d2_rd, d2_wr;
  logic [31:0] d2_alu, d2_val;
  logic [3:0]  d2_dest;
  logic        d2_freeze, d2_wb_out, d2_rd_out;
  logic [31:0] d2_alu_out, d2_mem_out;
  logic [3:0]  d2_dest_out;
  logic [17:0] d2_addr;
  logic [15:0] d2_dq_out, d2_dq_in;
  logic        d2_oe, d2_we_n;

  logic [15:0] mem [0:63];
  assign SRAM_DQ_In = mem[SRAM_ADDR[5:0]];
  assign d2_dq_in   = mem[d2_addr[5:0]];

  mem_stage_sram dut (
    .clk(clk), .rst(rst), .WB_ENIn(WB_ENIn), .MEM_R_ENIn(MEM_R_ENIn), .MEM_W_ENIn(MEM_W_ENIn),
    .ALU_ResIn(ALU_ResIn), .Val_RmIn(Val_RmIn), .DestIn(DestIn), .freezeOut(freezeOut),
    .WB_ENOut(WB_ENOut), .MEM_R_ENOut(MEM_R_ENOut), .ALU_ResOut(ALU_ResOut), .MEM_ResOut(MEM_ResOut),
    .DestOut(DestOut), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_Out(SRAM_DQ_Out), .SRAM_DQ_In(SRAM_DQ_In),
    .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_WE_N(SRAM_WE_N)
  );

  mem_stage_sram #(.WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .WB_ENIn(d2_wb), .MEM_R_ENIn(d2_rd), .MEM_W_ENIn(d2_wr),
    .ALU_ResIn(d2_alu), .Val_RmIn(d2_val), .DestIn(d2_dest), .freezeOut(d2_freeze),
    .WB_ENOut(d2_wb_out), .MEM_R_ENOut(d2_rd_out), .ALU_ResOut(d2_alu_out), .MEM_ResOut(d2_mem_out),
    .DestOut(d2_dest_out), .SRAM_ADDR(d2_addr), .SRAM_DQ_Out(d2_dq_out), .SRAM_DQ_In(d2_dq_in),
    .SRAM_DQ_OE(d2_oe), .SRAM_WE_N(d2_we_n)
  );

  typedef struct {
    logic [31:0] alu;
    logic [3:0]  dst;
    logic        rd;
    logic [31:0] res;
  } ret_t;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
  } wr_t;

  ret_t ret_q[$];
  wr_t  wr_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: retirements at WB and completed SRAM writes are popped against the scoreboards.
  logic prev_we_n = 1'b1;
  int   we_low_run = 0;
  always @(negedge clk) begin
    ret_t e;
    wr_t  w;
    if (rst === 1'b1) begin
      if (WB_ENOut) begin
        chk("retire_expected", 32'(ret_q.size() != 0), 32'd1);
        if (ret_q.size() != 0) begin
          e = ret_q.pop_front();
          chk("ret_alu", ALU_ResOut, e.alu);
          chk("ret_dest", 32'(DestOut), 32'(e.dst));
          chk("ret_mem_r_en", 32'(MEM_R_ENOut), 32'(e.rd));
          if (e.rd) chk("ret_mem_res", MEM_ResOut, e.res);
        end
      end
      if (!prev_we_n && SRAM_WE_N && SRAM_DQ_OE) begin
        chk("write_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          chk("wr_addr", 32'(SRAM_ADDR), 32'(w.addr));
          chk("wr_data", 32'(SRAM_DQ_Out), 32'(w.data));
          chk("we_low_cycles", 32'(we_low_run), 32'd4);
          mem[SRAM_ADDR[5:0]] = SRAM_DQ_Out;
        end
      end
    end
    if (!SRAM_WE_N) we_low_run++;
    else we_low_run = 0;
    prev_we_n = SRAM_WE_N;
  end

  // Apply one instruction just after a rising edge and hold it until the stage accepts it.
  task automatic issue(input logic wb, input logic rd, input logic wr, input logic [31:0] alu,
                       input logic [31:0] val, input logic [3:0] dst, input int exp_freeze);
    int fcnt;
    int idx;
    ret_t e;
    wr_t  w;
    WB_ENIn = wb; MEM_R_ENIn = rd; MEM_W_ENIn = wr;
    ALU_ResIn = alu; Val_RmIn = val; DestIn = dst;
    idx = int'((alu - 32'd1024) >> 2);
    if (wb) begin
      e.alu = alu; e.dst = dst; e.rd = rd;
      e.res = {mem[6'((idx * 2 + 1) % 64)], mem[6'((idx * 2) % 64)]};
      ret_q.push_back(e);
    end
    if (wr) begin
      w.addr = 18'(idx * 2);     w.data = val[15:0];  wr_q.push_back(w);
      w.addr = 18'(idx * 2 + 1); w.data = val[31:16]; wr_q.push_back(w);
    end
    fcnt = 0;
    @(negedge clk);
    while (freezeOut && fcnt < 64) begin
      fcnt++;
      @(negedge clk);
    end
    chk("freeze_cycles", 32'(fcnt), 32'(exp_freeze));
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    issue(1'b0, 1'b0, 1'b0, 32'h77, 32'h0, 4'd1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [17:0] seq [0:4];
    int fc;
    ret_t e;
    wr_t  w;

    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[0] = 16'h5678;
    mem[1] = 16'h1234;
    rst = 1'b0;
    WB_ENIn = 0; MEM_R_ENIn = 0; MEM_W_ENIn = 0; ALU_ResIn = 0; Val_RmIn = 0; DestIn = 0;
    d2_wb = 0; d2_rd = 0; d2_wr = 0; d2_alu = 0; d2_val = 0; d2_dest = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_en", 32'(WB_ENOut), 32'd0);
    chk("rst_alu_res", ALU_ResOut, 32'd0);
    chk("rst_mem_res", MEM_ResOut, 32'd0);
    chk("rst_freeze", 32'(freezeOut), 32'd0);
    chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
    chk("rst_oe", 32'(SRAM_DQ_OE), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    issue(1'b1, 1'b0, 1'b0, 32'h2A, 32'h0, 4'd3, 0);
    issue(1'b0, 1'b0, 1'b0, 32'h55, 32'h0, 4'd7, 0);
    issue(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'd5, 11);
    nop();
    issue(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd9, 11);
    nop();
    issue(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd4, 11);
    issue(1'b0, 1'b0, 1'b1, 32'd1036, 32'h01234567, 4'd0, 11);
    nop();
    chk("mem_word3_lo", 32'(mem[6]), 32'h4567);

    WB_ENIn = 0; MEM_R_ENIn = 0; MEM_W_ENIn = 1;
    ALU_ResIn = 32'd1032; Val_RmIn = 32'hCAFEF00D; DestIn = 4'd2;
    w.addr = 18'd4; w.data = 16'hF00D; wr_q.push_back(w);
    repeat (9) @(negedge clk);
    chk("pre_reset_addr", 32'(SRAM_ADDR), 32'd5);
    chk("pre_reset_we_n", 32'(SRAM_WE_N), 32'd0);
    rst = 1'b0;
    #1 chk("reset_freeze", 32'(freezeOut), 32'd0);
    @(negedge clk);
    chk("abort_we_n", 32'(SRAM_WE_N), 32'd1);
    chk("abort_oe", 32'(SRAM_DQ_OE), 32'd0);
    chk("abort_addr", 32'(SRAM_ADDR), 32'd0);
    chk("abort_wb_en", 32'(WB_ENOut), 32'd0);
    chk("abort_alu_res", ALU_ResOut, 32'd0);
    chk("abort_mem_res", MEM_ResOut, 32'd0);
    chk("abort_dest", 32'(DestOut), 32'd0);
    MEM_W_ENIn = 0; ALU_ResIn = 32'h77; Val_RmIn = 0; DestIn = 4'd1;
    @(posedge clk);
    #1 rst = 1'b1;

    issue(1'b1, 1'b0, 1'b0, 32'h1234_0000, 32'h0, 4'd11, 0);
    e.alu = 32'd1032; e.dst = 4'd12; e.rd = 1'b1; e.res = 32'h0000F00D;
    ret_q.push_back(e);
    issue(1'b0, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd12, 11);
    ret_q.pop_back();
    nop();

    d2_wb = 1; d2_rd = 1; d2_alu = 32'd1024; d2_dest = 4'd6;
    fc = 0;
    @(negedge clk);
    while (d2_freeze && fc < 32) begin
      if (fc < 5) seq[fc] = d2_addr;
      fc++;
      @(negedge clk);
    end
    chk("w2_freeze_cycles", 32'(fc), 32'd5);
    chk("w2_addr_l0", 32'(seq[1]), 32'd0);
    chk("w2_addr_l1", 32'(seq[2]), 32'd0);
    chk("w2_addr_h0", 32'(seq[3]), 32'd1);
    chk("w2_addr_h1", 32'(seq[4]), 32'd1);
    @(posedge clk);
    #1;
    chk("w2_mem_res", d2_mem_out, 32'h12345678);
    chk("w2_mem_r_en", 32'(d2_rd_out), 32'd1);
    chk("w2_wb_en", 32'(d2_wb_out), 32'd1);
    chk("w2_dest", 32'(d2_dest_out), 32'd6);
    d2_wb = 0; d2_rd = 0; d2_alu = 0; d2_dest = 0;

    repeat (3) @(negedge clk);
    chk("ret_queue_drained", 32'(ret_q.size()), 32'd0);
    chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
